// File: rtl/bytemask_pkg.sv
// Shared encodings for the byte-masked memory requester: access sizes,
// FSM states and the per-word byte-enable width.
package bytemask_pkg;

  localparam int MASK_W = 4;

  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;
  localparam logic [1:0] SIZE_X = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ACC0,
    ST_ACC1,
    ST_CAP,
    ST_RESP
  } state_e;

  // Right-justified byte-enable pattern for an access of the given size.
  function automatic logic [MASK_W-1:0] size_mask(input logic [1:0] size);
    logic [MASK_W-1:0] m;
    case (size)
      SIZE_B:  m = 4'b0001;
      SIZE_H:  m = 4'b0011;
      SIZE_W:  m = 4'b1111;
      default: m = 4'b0000;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/bytemask_align.sv
// Combinational lane steering: byte offset and size to a two-word mask and
// shifted store data, and a two-word read window back to extended load data.
module bytemask_align
  import bytemask_pkg::*;
(
  input  logic [1:0]          off_i,
  input  logic [1:0]          size_i,
  input  logic                uns_i,
  input  logic [31:0]         wdata_i,
  input  logic [31:0]         hi_i,
  input  logic [31:0]         lo_i,
  output logic [2*MASK_W-1:0] m8_o,
  output logic                cross_o,
  output logic [63:0]         d64_o,
  output logic [31:0]         ld_o
);

  logic [31:0] sh;

  assign m8_o    = {{MASK_W{1'b0}}, size_mask(size_i)} << off_i;
  assign cross_o = |m8_o[2*MASK_W-1:MASK_W];
  assign d64_o   = {32'b0, wdata_i} << {off_i, 3'b000};
  assign sh      = 32'({hi_i, lo_i} >> {off_i, 3'b000});

  always_comb begin
    ld_o = sh;
    case (size_i)
      SIZE_B:  ld_o = {{24{~uns_i & sh[7]}}, sh[7:0]};
      SIZE_H:  ld_o = {{16{~uns_i & sh[15]}}, sh[15:0]};
      default: ld_o = sh;
    endcase
  end

endmodule

// File: rtl/bytemask_mem_requester.sv
// Load/store requester for a byte-masked single-port word memory: masks and
// splits byte-addressed requests, then aligns and extends the read data.
module bytemask_mem_requester
  import bytemask_pkg::*;
#(
  parameter int ADDR_W   = 8,
  parameter bit SPLIT_EN = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [ADDR_W+1:0]   req_addr,
  input  logic [1:0]          req_size,
  input  logic                req_unsigned,
  input  logic [31:0]         req_wdata,
  output logic                resp_valid,
  input  logic                resp_ready,
  output logic [31:0]         resp_rdata,
  output logic                resp_err,
  output logic                c_en,
  output logic                wr,
  output logic [ADDR_W-1:0]   addr,
  output logic [MASK_W-1:0]   w_mask,
  output logic [31:0]         wr_data,
  input  logic [31:0]         rd_data
);

  state_e              state_q;
  logic                we_q;
  logic [1:0]          off_q;
  logic [1:0]          size_q;
  logic                uns_q;
  logic [31:0]         wdata_q;
  logic [ADDR_W-1:0]   word0_q;
  logic                cross_q;
  logic [31:0]         lo_q;

  logic                c_en_q;
  logic                wr_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [MASK_W-1:0]   w_mask_q;
  logic [31:0]         wr_data_q;
  logic                resp_valid_q;
  logic                resp_err_q;
  logic [31:0]         resp_rdata_q;

  logic                idle;
  logic [1:0]          al_off;
  logic [1:0]          al_size;
  logic [31:0]         al_wdata;
  logic [31:0]         al_hi;
  logic [31:0]         al_lo;
  logic [2*MASK_W-1:0] al_m8;
  logic                al_cross;
  logic [63:0]         al_d64;
  logic [31:0]         al_ld;

  assign idle = (state_q == ST_IDLE);

  // While idle the aligner looks at the incoming request so the first access
  // can be registered on the accepting edge; afterwards it uses the latched copy.
  assign al_off   = idle ? req_addr[1:0] : off_q;
  assign al_size  = idle ? req_size      : size_q;
  assign al_wdata = idle ? req_wdata     : wdata_q;
  assign al_hi    = cross_q ? rd_data : 32'h0;
  assign al_lo    = cross_q ? lo_q    : rd_data;

  bytemask_align u_align (
    .off_i   (al_off),
    .size_i  (al_size),
    .uns_i   (uns_q),
    .wdata_i (al_wdata),
    .hi_i    (al_hi),
    .lo_i    (al_lo),
    .m8_o    (al_m8),
    .cross_o (al_cross),
    .d64_o   (al_d64),
    .ld_o    (al_ld)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      we_q         <= 1'b0;
      off_q        <= 2'b0;
      size_q       <= SIZE_B;
      uns_q        <= 1'b0;
      wdata_q      <= 32'h0;
      word0_q      <= '0;
      cross_q      <= 1'b0;
      lo_q         <= 32'h0;
      c_en_q       <= 1'b0;
      wr_q         <= 1'b0;
      addr_q       <= '0;
      w_mask_q     <= '0;
      wr_data_q    <= 32'h0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= 32'h0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req_valid) begin
            we_q    <= req_we;
            off_q   <= req_addr[1:0];
            size_q  <= req_size;
            uns_q   <= req_unsigned;
            wdata_q <= req_wdata;
            word0_q <= req_addr[ADDR_W+1:2];
            cross_q <= al_cross;
            if (req_size == SIZE_X || (al_cross && !SPLIT_EN)) begin
              resp_valid_q <= 1'b1;
              resp_err_q   <= 1'b1;
              resp_rdata_q <= 32'h0;
              state_q      <= ST_RESP;
            end else begin
              c_en_q    <= 1'b1;
              wr_q      <= req_we;
              addr_q    <= req_addr[ADDR_W+1:2];
              w_mask_q  <= req_we ? al_m8[MASK_W-1:0] : '0;
              wr_data_q <= al_d64[31:0];
              state_q   <= ST_ACC0;
            end
          end
        end
        ST_ACC0: begin
          if (cross_q) begin
            addr_q    <= word0_q + ADDR_W'(1);
            w_mask_q  <= we_q ? al_m8[2*MASK_W-1:MASK_W] : '0;
            wr_data_q <= al_d64[63:32];
            state_q   <= ST_ACC1;
          end else begin
            c_en_q    <= 1'b0;
            wr_q      <= 1'b0;
            addr_q    <= '0;
            w_mask_q  <= '0;
            wr_data_q <= 32'h0;
            state_q   <= ST_CAP;
          end
        end
        ST_ACC1: begin
          // rd_data here belongs to the first (low) word access.
          lo_q      <= rd_data;
          c_en_q    <= 1'b0;
          wr_q      <= 1'b0;
          addr_q    <= '0;
          w_mask_q  <= '0;
          wr_data_q <= 32'h0;
          state_q   <= ST_CAP;
        end
        ST_CAP: begin
          resp_valid_q <= 1'b1;
          resp_err_q   <= 1'b0;
          resp_rdata_q <= we_q ? 32'h0 : al_ld;
          state_q      <= ST_RESP;
        end
        ST_RESP: begin
          if (resp_ready) begin
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= 32'h0;
            state_q      <= ST_IDLE;
          end
        end
        default: begin
          c_en_q       <= 1'b0;
          resp_valid_q <= 1'b0;
          state_q      <= ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(c_en_q && resp_valid_q));
      assert (!resp_valid_q || state_q == ST_RESP);
    end
  end

  assign req_ready  = idle && !rst;
  assign resp_valid = resp_valid_q;
  assign resp_err   = resp_err_q;
  assign resp_rdata = resp_rdata_q;
  assign c_en       = c_en_q;
  assign wr         = wr_q;
  assign addr       = addr_q;
  assign w_mask     = w_mask_q;
  assign wr_data    = wr_data_q;

endmodule
